// File: rtl/ball_motion_controller_pkg.sv
// Shared constants and state encoding for the ball motion controller and its helpers.
// Screen limits, keycodes and the per-frame FSM states live here so the mapper side can reuse them.
package ball_pkg;

   localparam logic [9:0] X_MIN     = 10'd0;
   localparam logic [9:0] X_MAX     = 10'd639;
   localparam logic [9:0] Y_MIN     = 10'd0;
   localparam logic [9:0] Y_MAX     = 10'd479;
   localparam logic [9:0] X_CENTER  = 10'd320;
   localparam logic [9:0] Y_CENTER  = 10'd240;
   localparam logic [9:0] STEP      = 10'd1;
   localparam logic [9:0] BALL_SIZE = 10'd4;

   // Bounce thresholds and the negative step, folded once here
   localparam logic [9:0] X_HI_LIMIT = X_MAX - BALL_SIZE;
   localparam logic [9:0] X_LO_LIMIT = X_MIN + BALL_SIZE;
   localparam logic [9:0] Y_HI_LIMIT = Y_MAX - BALL_SIZE;
   localparam logic [9:0] Y_LO_LIMIT = Y_MIN + BALL_SIZE;
   localparam logic [9:0] STEP_NEG   = ~STEP + 10'd1;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE   = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/ball_motion_controller_sync_edge_detect.sv
// Multi-flop synchroniser with a trailing history flop; emits a one-cycle pulse
// on each rising edge of an asynchronous input (e.g. VGA vertical sync).
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_pulse
);

   // chain_reg[SYNC_STAGES-1] is the synchronised level, chain_reg[SYNC_STAGES] its history
   logic [SYNC_STAGES:0] chain_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_reg <= '0;
      end else begin
         chain_reg <= {chain_reg[SYNC_STAGES-1:0], async_in};
      end
   end

   assign edge_pulse = chain_reg[SYNC_STAGES-1] & ~chain_reg[SYNC_STAGES];

endmodule

// File: rtl/ball_motion_controller.sv
// Once per video frame, samples the keycode, applies edge bounce and commits the
// new ball centre; frame timing comes from the synchronised vertical sync.
module ball_motion_controller
   import ball_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic       Pause,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] BallS,
   output logic       frame_done
);

   logic       frame_edge;
   state_t     state_reg, state_next;
   logic [9:0] ball_x_reg, ball_y_reg;
   logic [9:0] motion_x_reg, motion_x_next;
   logic [9:0] motion_y_reg, motion_y_next;
   logic       frame_done_reg;

   sync_edge_detect #(
      .SYNC_STAGES (2)
   ) u_frame_sync (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .async_in   (frame_clk),
      .edge_pulse (frame_edge)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg      <= IDLE;
         ball_x_reg     <= X_CENTER;
         ball_y_reg     <= Y_CENTER;
         motion_x_reg   <= '0;
         motion_y_reg   <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         motion_x_reg   <= motion_x_next;
         motion_y_reg   <= motion_y_next;
         frame_done_reg <= (state_reg == COMMIT);
         if (state_reg == COMMIT) begin
            ball_x_reg <= ball_x_reg + motion_x_reg;
            ball_y_reg <= ball_y_reg + motion_y_reg;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      motion_x_next = motion_x_reg;
      motion_y_next = motion_y_reg;
      case (state_reg)
         IDLE: begin
            if (frame_edge && !Pause) begin
               state_next = MOVE;
            end
         end
         MOVE: begin
            state_next = COMMIT;
            case (keycode)
               KEY_W: begin
                  motion_x_next = '0;
                  motion_y_next = STEP_NEG;
               end
               KEY_S: begin
                  motion_x_next = '0;
                  motion_y_next = STEP;
               end
               KEY_A: begin
                  motion_x_next = STEP_NEG;
                  motion_y_next = '0;
               end
               KEY_D: begin
                  motion_x_next = STEP;
                  motion_y_next = '0;
               end
               default: begin
               end
            endcase
            // Edge bounce overrides whatever the key asked for
            if (ball_x_reg >= X_HI_LIMIT) begin
               motion_x_next = STEP_NEG;
            end else if (ball_x_reg <= X_LO_LIMIT) begin
               motion_x_next = STEP;
            end
            if (ball_y_reg >= Y_HI_LIMIT) begin
               motion_y_next = STEP_NEG;
            end else if (ball_y_reg <= Y_LO_LIMIT) begin
               motion_y_next = STEP;
            end
         end
         COMMIT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign BallX      = ball_x_reg;
   assign BallY      = ball_y_reg;
   assign BallS      = BALL_SIZE;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ball_motion_controller.sv
// Directed bench for ball_motion_controller: a reference model queues the expected
// ball position per frame and a monitor checks it on every frame_done pulse.
module tb_ball_motion_controller;

   logic       Clk;
   logic       Reset_n;
   logic       frame_clk;
   logic [7:0] keycode;
   logic       Pause;
   logic [9:0] BallX;
   logic [9:0] BallY;
   logic [9:0] BallS;
   logic       frame_done;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } exp_t;

   exp_t exp_q[$];
   exp_t sb_item;

   int n_vectors     = 0;
   int n_miscompares = 0;
   int done_count    = 0;
   int frame_no      = 0;

   logic [9:0]        model_x;
   logic [9:0]        model_y;
   logic signed [9:0] model_mx;
   logic signed [9:0] model_my;

   ball_motion_controller dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_clk  (frame_clk),
      .keycode    (keycode),
      .Pause      (Pause),
      .BallX      (BallX),
      .BallY      (BallY),
      .BallS      (BallS),
      .frame_done (frame_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vectors++;
      assert (obs === exp) else begin
         n_miscompares++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference behaviour: key sets motion, edge proximity overrides it, then commit mod 1024
   task automatic model_step(input logic [7:0] key);
      case (key)
         8'h1A: begin model_mx = 10'sd0;  model_my = -10'sd1; end
         8'h16: begin model_mx = 10'sd0;  model_my = 10'sd1;  end
         8'h04: begin model_mx = -10'sd1; model_my = 10'sd0;  end
         8'h07: begin model_mx = 10'sd1;  model_my = 10'sd0;  end
         default: begin end
      endcase
      if (model_x >= 10'd635)     model_mx = -10'sd1;
      else if (model_x <= 10'd4)  model_mx = 10'sd1;
      if (model_y >= 10'd475)     model_my = -10'sd1;
      else if (model_y <= 10'd4)  model_my = 10'sd1;
      model_x = model_x + model_mx;
      model_y = model_y + model_my;
   endtask

   task automatic model_reset();
      model_x  = 10'd320;
      model_y  = 10'd240;
      model_mx = 10'sd0;
      model_my = 10'sd0;
      exp_q.delete();
   endtask

   // Scoreboard: every committed frame must match the oldest queued expectation
   always @(negedge Clk) begin
      if (Reset_n === 1'b1 && frame_done === 1'b1) begin
         done_count++;
         frame_no++;
         n_vectors++;
         assert (exp_q.size() != 0) else begin
            n_miscompares++;
            $error("FAIL sb_unexpected_done: observed=frame_done expected=no pending frame");
         end
         if (exp_q.size() != 0) begin
            sb_item = exp_q.pop_front();
            $display("frame %0d: BallX=%0d BallY=%0d (exp %0d,%0d)",
                     frame_no, BallX, BallY, sb_item.x, sb_item.y);
            check("sb_ballx", 32'(BallX), 32'(sb_item.x));
            check("sb_bally", 32'(BallY), 32'(sb_item.y));
         end
      end
   end

   task automatic do_reset();
      @(negedge Clk);
      Reset_n   = 1'b0;
      frame_clk = 1'b0;
      #1;
      check("rst_ballx", 32'(BallX), 32'd320);
      check("rst_bally", 32'(BallY), 32'd240);
      check("rst_done",  32'(frame_done), 32'd0);
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      model_reset();
   endtask

   task automatic run_frame(input logic [7:0] key, input logic pause_i, input int hold);
      int start_cnt;
      @(negedge Clk);
      keycode   = key;
      Pause     = pause_i;
      frame_clk = 1'b1;
      start_cnt = done_count;
      if (!pause_i) begin
         model_step(key);
         exp_q.push_back('{x: model_x, y: model_y});
      end
      repeat (hold) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (10) @(negedge Clk);
      check("done_pulses", 32'(done_count - start_cnt), pause_i ? 32'd0 : 32'd1);
      check("sb_drained",  32'(exp_q.size()), 32'd0);
      if (pause_i) begin
         check("pause_ballx", 32'(BallX), 32'(model_x));
         check("pause_bally", 32'(BallY), 32'(model_y));
      end
   endtask

   initial begin
      Reset_n   = 1'b0;
      frame_clk = 1'b0;
      keycode   = 8'h00;
      Pause     = 1'b0;
      model_reset();

      // Reset state, then a long vsync pulse with no key: one commit, no motion
      do_reset();
      check("balls", 32'(BallS), 32'd4);
      run_frame(8'h00, 1'b0, 100);
      check("t1_ballx", 32'(BallX), 32'd320);
      check("t1_bally", 32'(BallY), 32'd240);

      // Exact latency: rise before edge 1, commit at edge 5, pulse during the following cycle
      @(negedge Clk);
      keycode   = 8'h07;
      frame_clk = 1'b1;
      model_step(8'h07);
      exp_q.push_back('{x: model_x, y: model_y});
      repeat (4) @(posedge Clk);
      #1;
      check("lat_e4_ballx", 32'(BallX), 32'd320);
      check("lat_e4_done",  32'(frame_done), 32'd0);
      @(posedge Clk);
      #1;
      check("lat_e5_ballx", 32'(BallX), 32'd321);
      check("lat_e5_bally", 32'(BallY), 32'd240);
      check("lat_e5_done",  32'(frame_done), 32'd1);
      @(posedge Clk);
      #1;
      check("lat_e6_done",  32'(frame_done), 32'd0);
      @(negedge Clk);
      frame_clk = 1'b0;
      repeat (6) @(negedge Clk);
      check("lat_drained", 32'(exp_q.size()), 32'd0);

      // Hold D from reset through the right-edge bounce
      do_reset();
      for (int f = 1; f <= 317; f++) begin
         run_frame(8'h07, 1'b0, 4);
         if (f == 315) check("t3_f315_ballx", 32'(BallX), 32'd635);
         if (f == 316) check("t3_f316_ballx", 32'(BallX), 32'd634);
         if (f == 317) check("t3_f317_ballx", 32'(BallX), 32'd635);
      end

      // W once, then no key: upward motion persists
      do_reset();
      run_frame(8'h1A, 1'b0, 4);
      for (int f = 0; f < 10; f++) run_frame(8'h00, 1'b0, 4);
      check("t4_bally", 32'(BallY), 32'd229);
      check("t4_ballx", 32'(BallX), 32'd320);

      // Pause freezes position and suppresses frame_done; motion survives
      do_reset();
      run_frame(8'h07, 1'b0, 4);
      for (int f = 0; f < 5; f++) run_frame(8'h00, 1'b1, 4);
      check("t5_paused_ballx", 32'(BallX), 32'd321);
      run_frame(8'h00, 1'b0, 4);
      check("t5_resume_ballx", 32'(BallX), 32'd322);

      // Reset during the COMMIT cycle of the fourth move
      do_reset();
      for (int f = 0; f < 3; f++) run_frame(8'h07, 1'b0, 4);
      check("t6_pre_ballx", 32'(BallX), 32'd323);
      @(negedge Clk);
      keycode   = 8'h07;
      frame_clk = 1'b1;
      repeat (4) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check("t6_rst_ballx", 32'(BallX), 32'd320);
      check("t6_rst_bally", 32'(BallY), 32'd240);
      check("t6_rst_done",  32'(frame_done), 32'd0);
      @(negedge Clk);
      frame_clk = 1'b0;
      check("t6_nocommit_ballx", 32'(BallX), 32'd320);
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      model_reset();
      run_frame(8'h00, 1'b0, 4);
      check("t6_after_ballx", 32'(BallX), 32'd320);
      check("t6_after_bally", 32'(BallY), 32'd240);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
